// File: rtl/gamma_rgb_scheduler_pkg.sv
// Shared constants, pixel bundle and gamma table helpers for the
// gamma RGB scheduler: channel width, fixed-point scale, LUT geometry.
package gamma_rgb_scheduler_pkg;

    localparam int SIZE_INT        = 32;
    localparam int SCALE_BIT       = 8;
    localparam int GAMMA_MAX_INDEX = 255;
    localparam int LUT_DEPTH       = 256;
    localparam int LUT_IDX_W       = 8;

    typedef logic [SIZE_INT-1:0] chan_t;

    typedef struct packed {
        logic  en;
        chan_t r;
        chan_t g;
        chan_t b;
    } pix_t;

    // Table entry (i/256)^0.45 * 65536, truncated toward zero.
    // Only ever called with constant arguments at elaboration.
    function automatic chan_t gamma_entry(input int idx);
        real x;
        int  v;
        x = ($itor(idx) / 256.0) ** 0.45;
        v = $rtoi(x * 65536.0);
        return chan_t'(v);
    endfunction

endpackage

// File: rtl/gamma_rgb_scheduler_lut.sv
// Combinational gamma table, 256 entries, entry 0 = 0.
// Ports: index_i (8-bit LUT index), value_o (gamma-corrected value).
module gamma_lut
    import gamma_rgb_scheduler_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] index_i,
    output chan_t                value_o
);

    chan_t table_w [LUT_DEPTH];

    for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_entry
        localparam chan_t ENTRY = gamma_entry(i);
        assign table_w[i] = ENTRY;
    end

    assign value_o = table_w[index_i];

endmodule

// File: rtl/gamma_rgb_scheduler.sv
// Gamma-corrects an RGB pixel by time-sharing one LUT over R, G, B.
// Ports: clock, reset_n (sync, active-low), gamma_en, in_valid/in_ready,
// in_r/in_g/in_b, out_valid/out_ready, out_r/out_g/out_b.
module gamma_rgb_scheduler
    import gamma_rgb_scheduler_pkg::*;
#(
    parameter int MAX_INDEX = GAMMA_MAX_INDEX
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                gamma_en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE_INT-1:0] in_r,
    input  logic [SIZE_INT-1:0] in_g,
    input  logic [SIZE_INT-1:0] in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SIZE_INT-1:0] out_r,
    output logic [SIZE_INT-1:0] out_g,
    output logic [SIZE_INT-1:0] out_b
);

    typedef enum logic [2:0] {
        IDLE,
        R,
        G,
        B,
        OUT
    } state_t;

    localparam chan_t MAX_IDX = chan_t'(MAX_INDEX);

    state_t state_q, state_d;
    pix_t   pix_q, pix_d;
    chan_t  out_r_q, out_r_d;
    chan_t  out_g_q, out_g_d;
    chan_t  out_b_q, out_b_d;

    logic   accept;
    chan_t  chan_w;
    chan_t  shifted_w;
    chan_t  clamped_w;
    chan_t  lut_w;
    chan_t  result_w;

    assign in_ready = reset_n
                    & ((state_q == IDLE)
                    | ((state_q == OUT) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = reset_n & (state_q == OUT);

    always_comb begin
        chan_w = '0;
        unique case (state_q)
            R:       chan_w = pix_q.r;
            G:       chan_w = pix_q.g;
            B:       chan_w = pix_q.b;
            default: chan_w = '0;
        endcase
    end

    // Integer part of the fixed-point channel selects the entry.
    assign shifted_w = chan_w >> SCALE_BIT;
    assign clamped_w = (shifted_w > MAX_IDX) ? MAX_IDX : shifted_w;

    gamma_lut u_lut (
        .index_i (clamped_w[LUT_IDX_W-1:0]),
        .value_o (lut_w)
    );

    assign result_w = pix_q.en ? lut_w : chan_w;

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        out_r_d = out_r_q;
        out_g_d = out_g_q;
        out_b_d = out_b_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    pix_d   = '{en: gamma_en, r: in_r,
                                g: in_g, b: in_b};
                    state_d = R;
                end
            end
            R: begin
                out_r_d = result_w;
                state_d = G;
            end
            G: begin
                out_g_d = result_w;
                state_d = B;
            end
            B: begin
                out_b_d = result_w;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (accept) begin
                        pix_d   = '{en: gamma_en, r: in_r,
                                    g: in_g, b: in_b};
                        state_d = R;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pix_q   <= '0;
            out_r_q <= '0;
            out_g_q <= '0;
            out_b_q <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            out_r_q <= out_r_d;
            out_g_q <= out_g_d;
            out_b_q <= out_b_d;
        end
    end

    assign out_r = out_r_q;
    assign out_g = out_g_q;
    assign out_b = out_b_q;

endmodule
